axi_cut_reconfig_ctrl: RTL

Runtime controller that switches an AXI register-cut chain between registered and bypassed mode without corrupting in-flight traffic. It sits beside the cut chain on the same AXI path. It gates new AW/AR requests, drains outstanding write and read transactions, and flips the bypass select. It then waits a settle window and acknowledges the requester. It also caps outstanding transactions per direction.

---
 rtl/axi_cut_ctrl_pkg.sv | 18 +
 rtl/axi_txn_counter.sv | 34 +++
 rtl/axi_cut_reconfig_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/axi_cut_ctrl_pkg.sv
// Shared types for the AXI cut-chain reconfiguration controller.
// Holds the controller state encoding and the counter width helper.
package axi_cut_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE,
    ST_ACK
  } state_e;

  // Bits needed to hold 0..n inclusive, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating outstanding-transaction counter with full flag and underflow pulse.
// Count updates one cycle after inc/dec; full_o and underflow_o are combinational.
module axi_txn_counter
  import axi_cut_ctrl_pkg::*;
#(
  parameter int MaxTxns = 16,
  parameter int W       = cnt_width(MaxTxns)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         underflow_o
);

  localparam logic [W-1:0] MaxCnt = W'(MaxTxns);

  assign full_o      = (cnt_o == MaxCnt);
  // A same-cycle issue and response cancel, so only a lone response can underflow.
  assign underflow_o = dec_i & ~inc_i & (cnt_o == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_o <= cnt_o + W'(1);
    end else if (dec_i && !inc_i && cnt_o != '0) begin
      cnt_o <= cnt_o - W'(1);
    end
  end

endmodule

// File: rtl/axi_cut_reconfig_ctrl.sv
// Drains AXI traffic, flips the cut-chain bypass select, settles, then acks.
// AW/AR gating is a single AND on valid and ready; no added cycle on the AXI path.
module axi_cut_reconfig_ctrl
  import axi_cut_ctrl_pkg::*;
#(
  parameter int   MaxTxns      = 16,
  parameter int   SettleCycles = 2,
  parameter logic BypassRst    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cfg_req_i,
  input  logic cfg_bypass_i,
  output logic cfg_ack_o,
  output logic busy_o,
  output logic bypass_o,
  output logic protocol_err_o,
  input  logic slv_aw_valid_i,
  output logic slv_aw_ready_o,
  output logic mst_aw_valid_o,
  input  logic mst_aw_ready_i,
  input  logic slv_ar_valid_i,
  output logic slv_ar_ready_o,
  output logic mst_ar_valid_o,
  input  logic mst_ar_ready_i,
  input  logic mst_b_valid_i,
  input  logic mst_b_ready_i,
  input  logic mst_r_valid_i,
  input  logic mst_r_ready_i,
  input  logic mst_r_last_i
);

  localparam int CW = cnt_width(MaxTxns);
  localparam int SW = cnt_width(SettleCycles);

  state_e        state;
  logic          target;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          wr_full, rd_full, wr_unf, rd_unf;
  logic          aw_open, ar_open, aw_hs, ar_hs, b_hs, r_hs;

  assign aw_open = (state == ST_IDLE) & ~wr_full;
  assign ar_open = (state == ST_IDLE) & ~rd_full;

  assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
  assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
  assign mst_ar_valid_o = slv_ar_valid_i & ar_open;
  assign slv_ar_ready_o = mst_ar_ready_i & ar_open;

  assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
  assign b_hs  = mst_b_valid_i & mst_b_ready_i;
  assign r_hs  = mst_r_valid_i & mst_r_ready_i & mst_r_last_i;

  axi_txn_counter #(.MaxTxns(MaxTxns), .W(CW)) u_wr_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (aw_hs),
    .dec_i       (b_hs),
    .cnt_o       (wr_cnt),
    .full_o      (wr_full),
    .underflow_o (wr_unf)
  );

  axi_txn_counter #(.MaxTxns(MaxTxns), .W(CW)) u_rd_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (ar_hs),
    .dec_i       (r_hs),
    .cnt_o       (rd_cnt),
    .full_o      (rd_full),
    .underflow_o (rd_unf)
  );

  // Outputs are registered from the next-state decision so they line up with state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      target         <= BypassRst;
      settle_cnt     <= '0;
      bypass_o       <= BypassRst;
      cfg_ack_o      <= 1'b0;
      busy_o         <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      cfg_ack_o <= 1'b0;
      if (wr_unf || rd_unf) protocol_err_o <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (cfg_req_i) begin
            target <= cfg_bypass_i;
            busy_o <= 1'b1;
            if (cfg_bypass_i == bypass_o) begin
              state     <= ST_ACK;
              cfg_ack_o <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (wr_cnt == '0 && rd_cnt == '0) state <= ST_SWITCH;
        end
        ST_SWITCH: begin
          bypass_o   <= target;
          settle_cnt <= '0;
          if (SettleCycles > 0) begin
            state <= ST_SETTLE;
          end else begin
            state     <= ST_ACK;
            cfg_ack_o <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (int'(settle_cnt) >= SettleCycles - 1) begin
            state     <= ST_ACK;
            cfg_ack_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_ACK: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
